// File: rtl/hazard_detection.sv
// Decode-stage hazard unit: stalls the front end for load-use and decode-resolved
// branch dependencies, flushes IF/ID on taken branches, and keeps saturating statistics.
module hazard_detection #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic             idBranch,
  input  logic             branchTaken,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [4:0]       exWriteRegister,
  input  logic             memMemRead,
  input  logic [4:0]       memWriteRegister,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             idExBubble,
  output logic             ifIdFlush,
  output logic             stalling,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  logic [1:0] depth;
  logic       stall;

  // Register 0 is hardwired to zero, so it can never carry a real dependency.
  function automatic logic src_match(input logic [4:0] r);
    return (r != 5'd0) &&
           ((r == idRs) || ((idUsesRt || idBranch) && (r == idRt)));
  endfunction

  // NOTE: every signal driven in always_comb gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    depth = 2'd0;
    if (idBranch && exMemRead && src_match(exWriteRegister))
      depth = 2'd2;
    else if (exMemRead && src_match(exWriteRegister))
      depth = 2'd1;
    else if (idBranch && exRegWrite && src_match(exWriteRegister))
      depth = 2'd1;
    else if (idBranch && memMemRead && src_match(memWriteRegister))
      depth = 2'd1;
  end

  assign stall = (state == HOLD) || (depth != 2'd0);

  // Reset forces a bubble and a flush so nothing stale leaves decode.
  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    idExBubble = 1'b0;
    ifIdFlush  = 1'b0;
    stalling   = 1'b0;
    if (reset) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = 1'b1;
      ifIdFlush  = 1'b1;
    end else if (stall) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = 1'b1;
      stalling   = 1'b1;
    end else if (idBranch && branchTaken) begin
      ifIdFlush  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      state <= (state == RUN && depth == 2'd2) ? HOLD : RUN;
      if (stalling && stallCycles != CNT_MAX)
        stallCycles <= stallCycles + 1'b1;
      if (ifIdFlush && flushCount != CNT_MAX)
        flushCount <= flushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_detection.sv
// Directed-vector bench for hazard_detection: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against a default and a CNT_W=4 instance.
module tb_hazard_detection;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] idRs = '0, idRt = '0, exWriteRegister = '0, memWriteRegister = '0;
  logic       idUsesRt = 1'b0, idBranch = 1'b0, branchTaken = 1'b0;
  logic       exMemRead = 1'b0, exRegWrite = 1'b0, memMemRead = 1'b0;

  logic        pcWrite, ifIdWrite, idExBubble, ifIdFlush, stalling;
  logic [15:0] stallCycles, flushCount;
  logic        s_pcWrite, s_ifIdWrite, s_idExBubble, s_ifIdFlush, s_stalling;
  logic [3:0]  s_stallCycles, s_flushCount;

  always #5 clock = ~clock;

  hazard_detection dut (
    .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .idBranch(idBranch), .branchTaken(branchTaken), .exMemRead(exMemRead),
    .exRegWrite(exRegWrite), .exWriteRegister(exWriteRegister), .memMemRead(memMemRead),
    .memWriteRegister(memWriteRegister), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
    .idExBubble(idExBubble), .ifIdFlush(ifIdFlush), .stalling(stalling),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  hazard_detection #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
    .idBranch(idBranch), .branchTaken(branchTaken), .exMemRead(exMemRead),
    .exRegWrite(exRegWrite), .exWriteRegister(exWriteRegister), .memMemRead(memMemRead),
    .memWriteRegister(memWriteRegister), .pcWrite(s_pcWrite), .ifIdWrite(s_ifIdWrite),
    .idExBubble(s_idExBubble), .ifIdFlush(s_ifIdFlush), .stalling(s_stalling),
    .stallCycles(s_stallCycles), .flushCount(s_flushCount)
  );

  // Control bundle order: {pcWrite, ifIdWrite, idExBubble, ifIdFlush, stalling}
  localparam logic [4:0] NORM  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00101;
  localparam logic [4:0] FLUSH = 5'b11010;
  localparam logic [4:0] RST   = 5'b00110;

  typedef struct {
    string      name;
    logic [4:0] ctrl;
    int         st;
    int         fl;
    int         sat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.name, ".ctrl"}, int'({pcWrite, ifIdWrite, idExBubble, ifIdFlush, stalling}),
            int'(e.ctrl));
      check({e.name, ".stallCycles"}, int'(stallCycles), e.st);
      check({e.name, ".flushCount"}, int'(flushCount), e.fl);
      if (e.sat >= 0) check({e.name, ".satStall"}, int'(s_stallCycles), e.sat);
    end
  end

  // One cycle: apply inputs just after the edge and queue what the monitor must see.
  task automatic cyc(input string nm, input logic rst,
                     input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic br, input logic tk, input logic emr, input logic erw,
                     input logic [4:0] ewr, input logic mmr, input logic [4:0] mwr,
                     input logic [4:0] ctrl, input int st, input int fl, input int sat);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; idRs = rs; idRt = rt; idUsesRt = ur; idBranch = br; branchTaken = tk;
    exMemRead = emr; exRegWrite = erw; exWriteRegister = ewr;
    memMemRead = mmr; memWriteRegister = mwr;
    e.name = nm; e.ctrl = ctrl; e.st = st; e.fl = fl; e.sat = sat;
    q.push_back(e);
  endtask

  initial begin
    //   name        rst rs  rt  ur br tk emr erw ewr mmr mwr  ctrl  st fl sat
    cyc("reset0",    1, 0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  RST,   0, 0, -1);
    cyc("reset1",    1, 0,  0,  0, 1, 1, 1,  0,  0,  0,  0,  RST,   0, 0, -1);
    cyc("idle",      0, 0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  NORM,  0, 0, -1);
    // load-use on rs, then on rt, then rt without idUsesRt
    cyc("lu_rs",     0, 8,  0,  0, 0, 0, 1,  0,  8,  0,  0,  STALL, 0, 0, -1);
    cyc("lu_clear",  0, 8,  0,  0, 0, 0, 0,  0,  8,  0,  0,  NORM,  1, 0, -1);
    cyc("lu_rt",     0, 0,  8,  1, 0, 0, 1,  0,  8,  0,  0,  STALL, 1, 0, -1);
    cyc("rt_unused", 0, 0,  8,  0, 0, 0, 1,  0,  8,  0,  0,  NORM,  2, 0, -1);
    // load feeding a branch: HOLD ignores dropped load and branchTaken
    cyc("lb_run",    0, 0,  9,  0, 1, 0, 1,  0,  9,  0,  0,  STALL, 2, 0, -1);
    cyc("lb_hold",   0, 0,  9,  0, 1, 1, 0,  0,  0,  0,  0,  STALL, 3, 0, -1);
    cyc("lb_done",   0, 0,  9,  0, 1, 0, 0,  0,  0,  0,  0,  NORM,  4, 0, -1);
    // ALU result feeding a branch, then the branch resolves taken
    cyc("alu_br",    0, 10, 0,  0, 1, 0, 0,  1,  10, 0,  0,  STALL, 4, 0, -1);
    cyc("alu_take",  0, 10, 0,  0, 1, 1, 0,  0,  10, 0,  0,  FLUSH, 5, 0, -1);
    cyc("idle2",     0, 0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  NORM,  5, 1, -1);
    // load in EX/MEM feeding a branch; ALU/MEM matches without a branch never stall
    cyc("mem_br",    0, 11, 0,  0, 1, 0, 0,  0,  0,  1,  11, STALL, 5, 1, -1);
    cyc("idle3",     0, 0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  NORM,  6, 1, -1);
    cyc("alu_nobr",  0, 12, 0,  0, 0, 0, 0,  1,  12, 0,  0,  NORM,  6, 1, -1);
    cyc("mem_nobr",  0, 13, 0,  0, 0, 0, 0,  0,  0,  1,  13, NORM,  6, 1, -1);
    cyc("reg_zero",  0, 0,  0,  1, 1, 0, 1,  1,  0,  1,  0,  NORM,  6, 1, -1);
    // clean taken branch
    cyc("take",      0, 1,  2,  0, 1, 1, 0,  1,  3,  0,  0,  FLUSH, 6, 1, -1);
    cyc("idle4",     0, 0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  NORM,  6, 2, -1);
    // branchTaken during stalls must not flush
    cyc("tk_alu",    0, 5,  0,  0, 1, 1, 0,  1,  5,  0,  0,  STALL, 6, 2, -1);
    cyc("idle5",     0, 0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  NORM,  7, 2, -1);
    cyc("tk_lu",     0, 8,  0,  0, 0, 1, 1,  0,  8,  0,  0,  STALL, 7, 2, -1);
    cyc("idle6",     0, 0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  NORM,  8, 2, -1);
    // reset while in HOLD discards the extra stall
    cyc("h_enter",   0, 4,  0,  0, 1, 0, 1,  0,  4,  0,  0,  STALL, 8, 2, -1);
    cyc("h_reset",   1, 0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  RST,   9, 2, -1);
    cyc("h_after",   0, 0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  NORM,  0, 0, 0);
    // continuous hazard: 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++)
      cyc("sat",     0, 8,  0,  0, 0, 0, 1,  0,  8,  0,  0,  STALL, i, 0, (i > 15) ? 15 : i);
    cyc("sat_end",   0, 0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  NORM,  20, 0, 15);
    cyc("sat_hold",  0, 0,  0,  0, 0, 0, 0,  0,  0,  0,  0,  NORM,  20, 0, 15);

    @(negedge clock);
    #1;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_detection.md
# hazard_detection

Decode-stage hazard unit for the 5-stage MIPS pipeline, sitting directly upstream of the forwarding unit. It inspects the instruction in IF/ID against the ID/EX and EX/MEM latches. It stalls the front end for load-use and decode-resolved branch dependencies that forwarding cannot cover, inserts a bubble into ID/EX, and flushes IF/ID on taken branches. It also keeps saturating stall and flush statistics for the performance counters.

## Interface
Parameters:
- CNT_W, 16, width of the statistics counters

Ports:
- clock  input  1  pipeline clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- idRs  input  5  rs field of the instruction in IF/ID
- idRt  input  5  rt field of the instruction in IF/ID
- idUsesRt  input  1  the IF/ID instruction reads rt as a source (R-type, beq/bne, sw)
- idBranch  input  1  the IF/ID instruction is beq/bne, compared in ID
- branchTaken  input  1  ID comparator result, meaningful only when idBranch=1
- exMemRead  input  1  ID/EX instruction is a load
- exRegWrite  input  1  ID/EX instruction writes a register
- exWriteRegister  input  5  destination register of the ID/EX instruction
- memMemRead  input  1  EX/MEM instruction is a load
- memWriteRegister  input  5  destination register of the EX/MEM instruction
- pcWrite  output  1  PC load enable
- ifIdWrite  output  1  IF/ID load enable
- idExBubble  output  1  zero all control fields entering ID/EX this cycle
- ifIdFlush  output  1  replace the IF/ID contents with a nop at the next edge
- stalling  output  1  state/status: 1 while the unit is stalling, both initial and extended stall cycles
- stallCycles  output  CNT_W  saturating count of stall cycles since reset
- flushCount  output  CNT_W  saturating count of branch flushes since reset

## Operation
- Define `srcMatch(r)` as `(r != 0) && (r == idRs || ((idUsesRt || idBranch) && r == idRt))`.
- The required stall depth N is computed combinationally in state RUN:
  - N=2 if `idBranch && exMemRead && srcMatch(exWriteRegister)`.
  - Else N=1 if `exMemRead && srcMatch(exWriteRegister)`. This is the load-use case.
  - Else N=1 if `idBranch && exRegWrite && srcMatch(exWriteRegister)`. This is an ALU result needed by the ID comparator.
  - Else N=1 if `idBranch && memMemRead && srcMatch(memWriteRegister)`.
  - Else N=0.
- There are two FSM states, RUN and HOLD, and the FSM is registered.
  - In RUN with N=0, the state stays RUN.
  - In RUN with N=1, the state stays RUN; the stall is re-evaluated next cycle against the advanced pipeline.
  - In RUN with N=2, the state moves to HOLD.
  - HOLD moves to RUN unconditionally after exactly one cycle.
- Outputs are Mealy, combinational from the state and current inputs:
  - Stall condition: (RUN and N≥1) or HOLD. It drives pcWrite=0, ifIdWrite=0, idExBubble=1, ifIdFlush=0, and stalling=1.
  - Taken branch: not stalled, idBranch=1 and branchTaken=1. It drives pcWrite=1, ifIdWrite=1, idExBubble=0, and ifIdFlush=1.
  - Otherwise: pcWrite=1, ifIdWrite=1, idExBubble=0, ifIdFlush=0.
- branchTaken is ignored in any stalled cycle, because the operands are not yet valid.
- Counters update at the rising edge and saturate at 2^CNT_W−1 with no wrap:
  - stallCycles increments by 1 in each cycle where stalling=1.
  - flushCount increments by 1 in each cycle where ifIdFlush=1 and reset=0.
- Register 0 never causes a stall, regardless of any write-enable.

## Timing
- While reset=1:
  - Outputs are pcWrite=0, ifIdWrite=0, idExBubble=1, ifIdFlush=1, and stalling=0.
  - At the edge, the state goes to RUN and stallCycles and flushCount go to 0.
  - All other inputs are ignored.
- Reset asserted while in HOLD: the next state is RUN, and the extra stall cycle is discarded.
- Load-use: exactly 1 stall cycle. The dependent instruction re-decodes in the following cycle, and the forwarding unit supplies MEM/WB data.
- Load feeding a branch: exactly 2 stall cycles, the RUN cycle plus the HOLD cycle.
- ALU result feeding a branch: 1 stall cycle.
- Taken branch: one flush cycle, with zero stall penalty beyond that flush.
- Zero-latency decision: the outputs reflect same-cycle inputs. The only registered elements are the state and the counters.
- Saturated counter plus a new event: the count holds at its maximum value.

## Test plan
- Load-use:
  - Stimulus: exMemRead=1, exWriteRegister=8, idRs=8, idUsesRt=0.
  - Required response: one cycle of pcWrite=0, ifIdWrite=0, idExBubble=1, stallCycles=1.
  - Then drive exMemRead=0 and the stall must clear.
- Load feeding a branch:
  - Stimulus: idBranch=1, idRt=9, exMemRead=1, exWriteRegister=9, with the load inputs dropped after the first cycle.
  - Required response: the stall is still held for a 2nd cycle (HOLD), and stallCycles=2.
- Register zero:
  - Stimulus: exMemRead=1, exRegWrite=1, exWriteRegister=0, idRs=0, idBranch=1.
  - Required response: no stall, pcWrite=1.
- Taken branch without hazard:
  - Stimulus: idBranch=1, branchTaken=1, no register matches.
  - Required response: ifIdFlush=1, pcWrite=1, flushCount=1.
  - Also drive branchTaken=1 during a load-use stall; it must give no flush.
- Reset mid-HOLD:
  - Stimulus: enter HOLD, then assert reset for 1 cycle.
  - Required response: the counters return to 0, the state is RUN, and with hazard-free inputs stalling=0 on the next cycle.
- Saturation:
  - Stimulus: CNT_W=4, force a continuous hazard for 20 cycles.
  - Required response: stallCycles reads 15 and stays at 15.
